// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: RISC-V control-flow opcodes, predecode bit
// positions and the fetch-0 FSM encoding.
package fetch_pkg;

  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_BR   = 7'b1100011;

  localparam int unsigned PD_JAL  = 0;
  localparam int unsigned PD_JALR = 1;
  localparam int unsigned PD_BR   = 2;

  typedef enum logic {
    F0_RUN  = 1'b0,
    F0_SYNC = 1'b1
  } f0_state_e;

endpackage

// File: rtl/f0_predecode_slot.sv
// Combinational predecode of one instruction slot: control-flow flags, static
// redirect request and target. F0_BTFN_PREDICT_EN adds backward-taken branches.
module f0_predecode_slot
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W   = 64,
  parameter int unsigned INST_W = 32
) (
  input  logic [INST_W-1:0] inst_i,
  input  logic [PC_W-1:0]   pc_i,
  output logic [2:0]        pd_o,
  output logic              redir_o,
  output logic [PC_W-1:0]   target_o
);

  logic            is_jal;
  logic            is_jalr;
  logic            is_br;
  logic [PC_W-1:0] j_imm;
  logic [PC_W-1:0] b_imm;

  always_comb begin
    is_jal  = (inst_i[6:0] == OPC_JAL);
    is_jalr = (inst_i[6:0] == OPC_JALR);
    is_br   = (inst_i[6:0] == OPC_BR);

    j_imm = {{(PC_W-21){inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
             inst_i[30:21], 1'b0};
    b_imm = {{(PC_W-13){inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
             inst_i[11:8], 1'b0};

    pd_o          = '0;
    pd_o[PD_JAL]  = is_jal;
    pd_o[PD_JALR] = is_jalr;
    pd_o[PD_BR]   = is_br;

`ifdef F0_BTFN_PREDICT_EN
    // Backward branch (negative offset) is predicted taken.
    redir_o = is_jal | (is_br & inst_i[31]);
`else
    redir_o = is_jal;
`endif

    // Target only matters when redir_o is set; wraps modulo 2^PC_W.
    target_o = pc_i + (is_br ? b_imm : j_imm);
  end

endmodule

// File: rtl/fetch0_predecode.sv
// Fetch stage 0: pops instruction pairs, predecodes them, redirects statically on
// JAL and resynchronises to the expected PC. Option macro: F0_BTFN_PREDICT_EN.
module fetch0_predecode
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W   = 64,
  parameter int unsigned INST_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iq0_vld_i,
  input  logic [PC_W-1:0]   iq0_pc_i,
  input  logic [INST_W-1:0] iq0_inst_i,
  input  logic              iq1_vld_i,
  input  logic [PC_W-1:0]   iq1_pc_i,
  input  logic [INST_W-1:0] iq1_inst_i,
  output logic              stall_iq_o,
  output logic              flush_iq_o,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [PC_W-1:0]   flush_pc_i,
  output logic              f0_vld0_o,
  output logic [PC_W-1:0]   f0_pc0_o,
  output logic [INST_W-1:0] f0_inst0_o,
  output logic [2:0]        f0_pd0_o,
  output logic              f0_vld1_o,
  output logic [PC_W-1:0]   f0_pc1_o,
  output logic [INST_W-1:0] f0_inst1_o,
  output logic [2:0]        f0_pd1_o,
  output logic              redirect_vld_o,
  output logic [PC_W-1:0]   redirect_pc_o
);

  logic              take;
  logic              acc0, acc1;
  logic [2:0]        pd0, pd1;
  logic              req0, req1;
  logic [PC_W-1:0]   tgt0, tgt1;

  f0_state_e         state_q, state_d;
  logic [PC_W-1:0]   expect_q, expect_d;
  logic              vld0_q, vld0_d, vld1_q, vld1_d;
  logic [PC_W-1:0]   pc0_q, pc1_q;
  logic [INST_W-1:0] inst0_q, inst1_q;
  logic [2:0]        pd0_q, pd1_q;
  logic              redir_q, redir_d;
  logic [PC_W-1:0]   redir_pc_q, redir_pc_d;
  logic              flush_q, flush_d;

  f0_predecode_slot #(.PC_W(PC_W), .INST_W(INST_W)) u_slot0 (
    .inst_i   (iq0_inst_i),
    .pc_i     (iq0_pc_i),
    .pd_o     (pd0),
    .redir_o  (req0),
    .target_o (tgt0)
  );

  f0_predecode_slot #(.PC_W(PC_W), .INST_W(INST_W)) u_slot1 (
    .inst_i   (iq1_inst_i),
    .pc_i     (iq1_pc_i),
    .pd_o     (pd1),
    .redir_o  (req1),
    .target_o (tgt1)
  );

  assign take       = iq0_vld_i & iq1_vld_i & ~stall_i & ~flush_i;
  assign stall_iq_o = stall_i | flush_i;

  always_comb begin
    state_d    = state_q;
    expect_d   = expect_q;
    acc0       = 1'b0;
    acc1       = 1'b0;
    vld0_d     = vld0_q;
    vld1_d     = vld1_q;
    redir_d    = 1'b0;
    redir_pc_d = redir_pc_q;
    flush_d    = 1'b0;

    if (take) begin
      if (state_q == F0_RUN) begin
        acc0 = 1'b1;
        acc1 = 1'b1;
      end else if (iq0_pc_i == expect_q) begin
        acc0    = 1'b1;
        acc1    = 1'b1;
        state_d = F0_RUN;
      end else if (iq1_pc_i == expect_q) begin
        acc1    = 1'b1;
        state_d = F0_RUN;
      end

      // Older slot wins; a redirecting slot0 kills its younger neighbour.
      if (acc0 && req0) begin
        acc1       = 1'b0;
        redir_d    = 1'b1;
        redir_pc_d = tgt0;
      end else if (acc1 && req1) begin
        redir_d    = 1'b1;
        redir_pc_d = tgt1;
      end

      if (redir_d) begin
        flush_d  = 1'b1;
        expect_d = redir_pc_d;
        state_d  = F0_SYNC;
      end
    end

    if (flush_i) begin
      vld0_d   = 1'b0;
      vld1_d   = 1'b0;
      flush_d  = 1'b1;
      expect_d = flush_pc_i;
      state_d  = F0_SYNC;
    end else if (!stall_i) begin
      vld0_d = acc0;
      vld1_d = acc1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= F0_RUN;
      expect_q   <= '0;
      vld0_q     <= 1'b0;
      vld1_q     <= 1'b0;
      pc0_q      <= '0;
      pc1_q      <= '0;
      inst0_q    <= '0;
      inst1_q    <= '0;
      pd0_q      <= '0;
      pd1_q      <= '0;
      redir_q    <= 1'b0;
      redir_pc_q <= '0;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      expect_q   <= expect_d;
      vld0_q     <= vld0_d;
      vld1_q     <= vld1_d;
      redir_q    <= redir_d;
      redir_pc_q <= redir_pc_d;
      flush_q    <= flush_d;
      if (take) begin
        pc0_q   <= iq0_pc_i;
        pc1_q   <= iq1_pc_i;
        inst0_q <= iq0_inst_i;
        inst1_q <= iq1_inst_i;
        pd0_q   <= pd0;
        pd1_q   <= pd1;
      end
    end
  end

  assign f0_vld0_o      = vld0_q;
  assign f0_pc0_o       = pc0_q;
  assign f0_inst0_o     = inst0_q;
  assign f0_pd0_o       = pd0_q;
  assign f0_vld1_o      = vld1_q;
  assign f0_pc1_o       = pc1_q;
  assign f0_inst1_o     = inst1_q;
  assign f0_pd1_o       = pd1_q;
  // A backend flush arriving with the pulse cancels it.
  assign redirect_vld_o = redir_q & ~flush_i;
  assign redirect_pc_o  = redir_pc_q;
  assign flush_iq_o     = flush_q;

endmodule

// File: tb/tb_fetch0_predecode.sv
// Scoreboard bench for fetch0_predecode: expected outputs are queued as each pair
// is driven and compared one cycle later.
module tb_fetch0_predecode;

  localparam logic [31:0] ADDI     = 32'h00100093;
  localparam logic [31:0] NOP      = 32'h00000013;
  localparam logic [31:0] JAL_P100 = 32'h100000EF;
  localparam logic [31:0] JAL_M8   = 32'hFF9FF06F;
  localparam logic [31:0] BEQ_M16  = 32'hFE0008E3;
  localparam logic [31:0] BEQ_P16  = 32'h00000863;

  typedef struct packed {
    logic        v0;
    logic [63:0] pc0;
    logic [31:0] i0;
    logic [2:0]  pd0;
    logic        v1;
    logic [63:0] pc1;
    logic [31:0] i1;
    logic [2:0]  pd1;
    logic        rv;
    logic [63:0] rpc;
    logic        fiq;
  } out_t;

  typedef struct packed {
    logic        v0;
    logic        v1;
    logic [63:0] pc0;
    logic [31:0] i0;
    logic [31:0] i1;
    logic        st;
    logic        fl;
    logic [63:0] fpc;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iq0_vld_i = 1'b0, iq1_vld_i = 1'b0;
  logic [63:0] iq0_pc_i = '0, iq1_pc_i = '0;
  logic [31:0] iq0_inst_i = '0, iq1_inst_i = '0;
  logic        stall_i = 1'b0, flush_i = 1'b0;
  logic [63:0] flush_pc_i = '0;
  logic        stall_iq_o, flush_iq_o;
  logic        f0_vld0_o, f0_vld1_o;
  logic [63:0] f0_pc0_o, f0_pc1_o;
  logic [31:0] f0_inst0_o, f0_inst1_o;
  logic [2:0]  f0_pd0_o, f0_pd1_o;
  logic        redirect_vld_o;
  logic [63:0] redirect_pc_o;

  out_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fetch0_predecode #(.PC_W(64), .INST_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .iq0_vld_i      (iq0_vld_i),
    .iq0_pc_i       (iq0_pc_i),
    .iq0_inst_i     (iq0_inst_i),
    .iq1_vld_i      (iq1_vld_i),
    .iq1_pc_i       (iq1_pc_i),
    .iq1_inst_i     (iq1_inst_i),
    .stall_iq_o     (stall_iq_o),
    .flush_iq_o     (flush_iq_o),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .flush_pc_i     (flush_pc_i),
    .f0_vld0_o      (f0_vld0_o),
    .f0_pc0_o       (f0_pc0_o),
    .f0_inst0_o     (f0_inst0_o),
    .f0_pd0_o       (f0_pd0_o),
    .f0_vld1_o      (f0_vld1_o),
    .f0_pc1_o       (f0_pc1_o),
    .f0_inst1_o     (f0_inst1_o),
    .f0_pd1_o       (f0_pd1_o),
    .redirect_vld_o (redirect_vld_o),
    .redirect_pc_o  (redirect_pc_o)
  );

  // Slot payloads are don't-care while invalid, as is the target without a pulse.
  function automatic out_t eo(logic v0, logic [63:0] pc0, logic [31:0] i0, logic [2:0] pd0,
                              logic v1, logic [63:0] pc1, logic [31:0] i1, logic [2:0] pd1,
                              logic rv, logic [63:0] rpc, logic fiq);
    out_t o;
    o.v0  = v0;
    o.pc0 = v0 ? pc0 : '0;
    o.i0  = v0 ? i0 : '0;
    o.pd0 = v0 ? pd0 : '0;
    o.v1  = v1;
    o.pc1 = v1 ? pc1 : '0;
    o.i1  = v1 ? i1 : '0;
    o.pd1 = v1 ? pd1 : '0;
    o.rv  = rv;
    o.rpc = rv ? rpc : '0;
    o.fiq = fiq;
    return o;
  endfunction

  function automatic out_t zero(logic fiq);
    return eo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, fiq);
  endfunction

  function automatic out_t sample();
    return eo(f0_vld0_o, f0_pc0_o, f0_inst0_o, f0_pd0_o, f0_vld1_o, f0_pc1_o, f0_inst1_o,
              f0_pd1_o, redirect_vld_o, redirect_pc_o, flush_iq_o);
  endfunction

  function automatic stim_t sp(logic v0, logic v1, logic [63:0] pc0, logic [31:0] i0,
                               logic [31:0] i1, logic st, logic fl, logic [63:0] fpc);
    stim_t s;
    s.v0 = v0; s.v1 = v1; s.pc0 = pc0; s.i0 = i0; s.i1 = i1;
    s.st = st; s.fl = fl; s.fpc = fpc;
    return s;
  endfunction

  function automatic stim_t pair(logic [63:0] pc0, logic [31:0] i0, logic [31:0] i1);
    return sp(1, 1, pc0, i0, i1, 0, 0, 0);
  endfunction

  task automatic set_in(input stim_t s);
    iq0_vld_i  = s.v0;
    iq1_vld_i  = s.v1;
    iq0_pc_i   = s.pc0;
    iq1_pc_i   = s.pc0 + 64'd4;
    iq0_inst_i = s.i0;
    iq1_inst_i = s.i1;
    stall_i    = s.st;
    flush_i    = s.fl;
    flush_pc_i = s.fpc;
  endtask

  task automatic drive(input stim_t s, input out_t e);
    set_in(s);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    out_t got;
    #2;
    got = sample();
    n_chk++;
    if (got !== zero(0) || stall_iq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: got %h stall_iq=%b want all zero", got, stall_iq_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    got = sample();
    n_chk++;
    if (got !== zero(0)) begin
      n_fail++;
      $display("FAIL reset_release: got %h want all zero", got);
    end
  endtask

  task automatic test_basic();
    stim_t s[2];
    out_t  e[2];
    out_t  got, want;
    s[0] = pair(64'h1000, ADDI, ADDI);
    e[0] = eo(1, 64'h1000, ADDI, 3'b000, 1, 64'h1004, ADDI, 3'b000, 0, 0, 0);
    s[1] = sp(0, 0, 0, 0, 0, 0, 0, 0);
    e[1] = zero(0);
    for (int k = 0; k < 2; k++) begin
      drive(s[k], e[k]);
      got = sample(); want = sb.pop_front(); n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL basic[%0d]: got %h want %h", k, got, want);
      end
    end
  endtask

  task automatic test_jal_slot0();
    stim_t s[4];
    out_t  e[4];
    out_t  got, want;
    s[0] = pair(64'h2000, JAL_P100, NOP);
    e[0] = eo(1, 64'h2000, JAL_P100, 3'b001, 0, 0, 0, 0, 1, 64'h2100, 1);
    s[1] = pair(64'h2008, ADDI, ADDI);  e[1] = zero(0);
    s[2] = pair(64'h2010, ADDI, ADDI);  e[2] = zero(0);
    s[3] = pair(64'h2100, ADDI, NOP);
    e[3] = eo(1, 64'h2100, ADDI, 3'b000, 1, 64'h2104, NOP, 3'b000, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      drive(s[k], e[k]);
      got = sample(); want = sb.pop_front(); n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL jal_slot0[%0d]: got %h want %h", k, got, want);
      end
    end
  endtask

  task automatic test_jal_slot1();
    stim_t s[4];
    out_t  e[4];
    out_t  got, want;
    s[0] = pair(64'h3000, NOP, JAL_M8);
    e[0] = eo(1, 64'h3000, NOP, 3'b000, 1, 64'h3004, JAL_M8, 3'b001, 1, 64'h2FFC, 1);
    s[1] = pair(64'h3008, ADDI, ADDI);  e[1] = zero(0);
    s[2] = pair(64'h2FF8, ADDI, NOP);
    e[2] = eo(0, 0, 0, 0, 1, 64'h2FFC, NOP, 3'b000, 0, 0, 0);
    s[3] = pair(64'h3000, ADDI, ADDI);
    e[3] = eo(1, 64'h3000, ADDI, 3'b000, 1, 64'h3004, ADDI, 3'b000, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      drive(s[k], e[k]);
      got = sample(); want = sb.pop_front(); n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL jal_slot1[%0d]: got %h want %h", k, got, want);
      end
    end
  endtask

  task automatic test_stall();
    stim_t s[4];
    out_t  e[4];
    logic  siq[4];
    out_t  got, want;
    for (int k = 0; k < 3; k++) begin
      s[k]   = sp(1, 1, 64'h5000, ADDI, NOP, 1, 0, 0);
      e[k]   = eo(1, 64'h3000, ADDI, 3'b000, 1, 64'h3004, ADDI, 3'b000, 0, 0, 0);
      siq[k] = 1'b1;
    end
    s[3]   = pair(64'h5000, ADDI, NOP);
    e[3]   = eo(1, 64'h5000, ADDI, 3'b000, 1, 64'h5004, NOP, 3'b000, 0, 0, 0);
    siq[3] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(s[k], e[k]);
      got = sample(); want = sb.pop_front(); n_chk++;
      if (got !== want || stall_iq_o !== siq[k]) begin
        n_fail++;
        $display("FAIL stall[%0d]: got %h stall_iq=%b want %h stall_iq=%b",
                 k, got, stall_iq_o, want, siq[k]);
      end
    end
  endtask

  task automatic test_flush_jal();
    stim_t s[4];
    out_t  e[4];
    out_t  got, want;
    s[0] = sp(1, 1, 64'h6000, JAL_P100, NOP, 0, 1, 64'h8000);  e[0] = zero(1);
    s[1] = sp(1, 1, 64'h8000, ADDI, ADDI, 1, 0, 0);            e[1] = zero(0);
    s[2] = pair(64'h7000, ADDI, ADDI);                          e[2] = zero(0);
    s[3] = pair(64'h8000, ADDI, ADDI);
    e[3] = eo(1, 64'h8000, ADDI, 3'b000, 1, 64'h8004, ADDI, 3'b000, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      drive(s[k], e[k]);
      got = sample(); want = sb.pop_front(); n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL flush_jal[%0d]: got %h want %h", k, got, want);
      end
    end
  endtask

  task automatic test_flush_kill();
    stim_t s[3];
    out_t  e[3];
    out_t  got, want;
    s[0] = pair(64'h2000, JAL_P100, NOP);
    e[0] = eo(1, 64'h2000, JAL_P100, 3'b001, 0, 0, 0, 0, 1, 64'h2100, 1);
    s[1] = sp(0, 0, 0, 0, 0, 0, 1, 64'hC000);
    e[1] = zero(1);
    s[2] = pair(64'hC000, ADDI, NOP);
    e[2] = eo(1, 64'hC000, ADDI, 3'b000, 1, 64'hC004, NOP, 3'b000, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin
        set_in(s[k]);
        #1;
        n_chk++;
        if (redirect_vld_o !== 1'b0) begin
          n_fail++;
          $display("FAIL flush_kill_pulse: redirect_vld_o=%b want 0", redirect_vld_o);
        end
      end
      drive(s[k], e[k]);
      got = sample(); want = sb.pop_front(); n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL flush_kill[%0d]: got %h want %h", k, got, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t s[3];
    out_t  e[3];
    out_t  got, want;
    s[0] = pair(64'h9000, JAL_P100, NOP);
    e[0] = eo(1, 64'h9000, JAL_P100, 3'b001, 0, 0, 0, 0, 1, 64'h9100, 1);
    s[1] = pair(64'h9100, ADDI, JAL_M8);
    e[1] = eo(1, 64'h9100, ADDI, 3'b000, 1, 64'h9104, JAL_M8, 3'b001, 1, 64'h90FC, 1);
    s[2] = pair(64'h90F8, NOP, ADDI);
    e[2] = eo(0, 0, 0, 0, 1, 64'h90FC, ADDI, 3'b000, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive(s[k], e[k]);
      got = sample(); want = sb.pop_front(); n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got %h want %h", k, got, want);
      end
    end
  endtask

  task automatic test_single_valid();
    stim_t s[3];
    out_t  e[3];
    out_t  got, want;
    s[0] = sp(1, 0, 64'hD000, ADDI, ADDI, 0, 0, 0);  e[0] = zero(0);
    s[1] = sp(0, 1, 64'hD000, ADDI, ADDI, 0, 0, 0);  e[1] = zero(0);
    s[2] = pair(64'hD000, NOP, ADDI);
    e[2] = eo(1, 64'hD000, NOP, 3'b000, 1, 64'hD004, ADDI, 3'b000, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive(s[k], e[k]);
      got = sample(); want = sb.pop_front(); n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL single_valid[%0d]: got %h want %h", k, got, want);
      end
    end
  endtask

  task automatic test_btfn();
    stim_t s[3];
    out_t  e[3];
    out_t  got, want;
    s[0] = pair(64'h4000, BEQ_P16, NOP);
    e[0] = eo(1, 64'h4000, BEQ_P16, 3'b100, 1, 64'h4004, NOP, 3'b000, 0, 0, 0);
    s[1] = pair(64'h4000, BEQ_M16, ADDI);
`ifdef F0_BTFN_PREDICT_EN
    e[1] = eo(1, 64'h4000, BEQ_M16, 3'b100, 0, 0, 0, 0, 1, 64'h3FF0, 1);
`else
    e[1] = eo(1, 64'h4000, BEQ_M16, 3'b100, 1, 64'h4004, ADDI, 3'b000, 0, 0, 0);
`endif
    s[2] = pair(64'h3FF0, ADDI, ADDI);
    e[2] = eo(1, 64'h3FF0, ADDI, 3'b000, 1, 64'h3FF4, ADDI, 3'b000, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive(s[k], e[k]);
      got = sample(); want = sb.pop_front(); n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL btfn[%0d]: got %h want %h", k, got, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    out_t got, want;
    set_in(pair(64'hA000, JAL_P100, NOP));
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    got = sample();
    n_chk++;
    if (got !== zero(0)) begin
      n_fail++;
      $display("FAIL reset_mid: got %h want all zero", got);
    end
    set_in(sp(0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(pair(64'hB000, ADDI, NOP),
          eo(1, 64'hB000, ADDI, 3'b000, 1, 64'hB004, NOP, 3'b000, 0, 0, 0));
    got = sample(); want = sb.pop_front(); n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL reset_mid_run: got %h want %h", got, want);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_jal_slot0();
    test_jal_slot1();
    test_stall();
    test_flush_jal();
    test_flush_kill();
    test_back_to_back();
    test_single_valid();
    test_btfn();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch0_predecode.md
Name: fetch0_predecode

Overview:
- Fetch stage 0. Sits directly downstream of the instruction queue.
- Each cycle it pops a 2-instruction pair from the queue, predecodes each slot, and registers the pair toward decode.
- On a direct jump (JAL) it redirects the front end statically: one-cycle redirect pulse plus queue flush.
- After a redirect or a backend flush it discards wrong-path pairs until the PC matches the expected target.

Parameters:
- PC_W, 64, PC width.
- INST_W, 32, instruction width.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- iq0_vld_i  in  1  queue slot0 valid
- iq0_pc_i  in  PC_W  slot0 PC
- iq0_inst_i  in  INST_W  slot0 instruction
- iq1_vld_i  in  1  queue slot1 valid
- iq1_pc_i  in  PC_W  slot1 PC (= iq0_pc_i+4)
- iq1_inst_i  in  INST_W  slot1 instruction
- stall_iq_o  out  1  hold queue read pointer
- flush_iq_o  out  1  clear queue contents
- stall_i  in  1  backend stall
- flush_i  in  1  backend flush
- flush_pc_i  in  PC_W  restart PC carried with flush_i
- f0_vld0_o  out  1  output slot0 valid
- f0_pc0_o  out  PC_W  slot0 PC
- f0_inst0_o  out  INST_W  slot0 instruction
- f0_pd0_o  out  3  slot0 predecode {is_br,is_jalr,is_jal}
- f0_vld1_o  out  1  output slot1 valid
- f0_pc1_o  out  PC_W  slot1 PC
- f0_inst1_o  out  INST_W  slot1 instruction
- f0_pd1_o  out  3  slot1 predecode
- redirect_vld_o  out  1  front-end redirect pulse
- redirect_pc_o  out  PC_W  redirect target

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
  - All outputs are 0 after reset; state=RUN; expect_pc=0.
  - Reset mid-operation drops any in-flight pair and any pending redirect.
- Take condition: take = iq0_vld_i & iq1_vld_i & ~stall_i & ~flush_i.
  - stall_iq_o = stall_i | flush_i. The queue pops only when take=1.
- Predecode, from inst[6:0]:
  - JAL = 1101111, JALR = 1100111, BR = 1100011.
  - J-imm = sext{i[31],i[19:12],i[20],i[30:21],1'b0}.
  - B-imm = sext{i[31],i[7],i[30:25],i[11:8],1'b0}.
  - Target = pc + imm, modulo 2^PC_W (wrap ignored).
- Latency: a pair taken in cycle N appears on f0_* in cycle N+1.
- Output registers:
  - Load when ~stall_i.
  - Hold while stall_i=1.
  - When ~stall_i & ~take, valids are cleared.
- FSM RUN:
  - Every taken pair is accepted.
  - If slot0 is JAL: slot1 valid is forced to 0; target = pc0 + J-imm0.
  - Else if slot1 is JAL: target = pc1 + J-imm1.
  - On a JAL, the next cycle gives redirect_vld_o=1 (one cycle, ignores stall_i), redirect_pc_o=target, and flush_iq_o=1.
  - On a JAL, expect_pc <= target and the state goes to SYNC.
- FSM SYNC:
  - Taken pairs are consumed but discarded unless iq0_pc_i==expect_pc (accept both slots) or iq1_pc_i==expect_pc (slot0 valid forced to 0, slot1 accepted).
  - On a match, the state returns to RUN. The accepted slots get the same JAL rules as RUN and may redirect again.
- Backend flush (flush_i=1):
  - Output valids clear next cycle; flush_iq_o=1 next cycle.
  - expect_pc <= flush_pc_i; state goes to SYNC.
  - No redirect_vld_o is generated.
  - flush_i beats a same-cycle JAL detection and also suppresses a redirect pulse already registered for the next cycle.
- JALR and BR are flagged in f0_pd only; neither causes a redirect (except under the optional feature).
- Boundaries:
  - Single valid queue slot: no take.
  - Stall during SYNC: the state is held.
  - Back-to-back redirects are legal once SYNC matches.

Optional Feature:
- Macro F0_BTFN_PREDICT_EN.
- Defined: a conditional branch with negative B-imm (i[31]=1) is predicted taken and treated exactly like JAL.
  - Redirect to pc + B-imm; younger slot dropped; flush_iq_o; SYNC.
  - Slot0 branch has priority over slot1.
- Undefined: branches never redirect; f0_pd is unchanged.

Decomposition:
- Shared package fetch_pkg:
  - Opcode constants OPC_JAL, OPC_JALR, OPC_BR.
  - Predecode bit positions PD_JAL=0, PD_JALR=1, PD_BR=2.
  - FSM encoding F0_RUN=1'b0, F0_SYNC=1'b1.
- One combinational sub-module, f0_predecode_slot, instantiated twice.
  - Inputs: inst, pc.
  - Outputs: pd[2:0], redirect request, target.

Test Plan:
- Reset, then pair pc0=0x1000 ADDI/ADDI with no stall -> next cycle vld0=vld1=1, pcs 0x1000/0x1004, pd=0, redirect_vld_o=0.
- Slot0 JAL imm=+0x100 at pc0=0x2000 -> vld0=1, vld1=0, redirect_vld_o=1 with redirect_pc_o=0x2100, flush_iq_o=1; then pairs at 0x2008 are dropped and the pair at 0x2100 is accepted.
- Slot1 JAL imm=-8 at pc1=0x3004 -> both valid, redirect_pc_o=0x2FFC; SYNC then accepts pair 0x2FF8/0x2FFC with vld0=0, vld1=1.
- stall_i held 3 cycles with a valid pair -> stall_iq_o=1, outputs frozen, no pop; release -> pair consumed on the first free cycle.
- flush_i with flush_pc_i=0x8000 in the same cycle as a slot0 JAL -> no redirect_vld_o, flush_iq_o=1, valids=0; pair 0x8000 accepted afterwards.
- F0_BTFN_PREDICT_EN: BEQ imm=-16 at pc0=0x4000 -> redirect 0x3FF0; BEQ imm=+16 -> no redirect. Without the macro, neither redirects.
